// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_arbiter.
//  master : the arbiter's view. It receives the EX data request, the IF fetch
//           request and the memory ack/read data. It drives completion, stall
//           and the memory command.
//  slave  : the surrounding pipeline and memory (testbench) view.
// Port summary (master direction):
//  in  d_req_addr, d_req_wr_data, d_req_wr_en, d_req_count   EX data request
//  out d_done, d_rd_data, d_stall                            EX completion/stall
//  in  i_req, i_req_addr                                     IF fetch request
//  out i_done, i_rd_data, i_stall                            IF completion/stall
//  out m_req, m_addr, m_wr_data, m_wr_en, m_count            memory command
//  in  m_ack, m_rd_data                                      memory response
interface mem_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int COUNT_W = 2
);
  logic [ADDR_W-1:0]  d_req_addr;
  logic [WORD_W-1:0]  d_req_wr_data;
  logic               d_req_wr_en;
  logic [COUNT_W-1:0] d_req_count;
  logic               d_done;
  logic [WORD_W-1:0]  d_rd_data;
  logic               d_stall;

  logic               i_req;
  logic [ADDR_W-1:0]  i_req_addr;
  logic               i_done;
  logic [WORD_W-1:0]  i_rd_data;
  logic               i_stall;

  logic               m_req;
  logic [ADDR_W-1:0]  m_addr;
  logic [WORD_W-1:0]  m_wr_data;
  logic               m_wr_en;
  logic [COUNT_W-1:0] m_count;
  logic               m_ack;
  logic [WORD_W-1:0]  m_rd_data;

  modport master (
    input  d_req_addr, d_req_wr_data, d_req_wr_en, d_req_count,
    input  i_req, i_req_addr,
    input  m_ack, m_rd_data,
    output d_done, d_rd_data, d_stall,
    output i_done, i_rd_data, i_stall,
    output m_req, m_addr, m_wr_data, m_wr_en, m_count
  );

  modport slave (
    output d_req_addr, d_req_wr_data, d_req_wr_en, d_req_count,
    output i_req, i_req_addr,
    output m_ack, m_rd_data,
    input  d_done, d_rd_data, d_stall,
    input  i_done, i_rd_data, i_stall,
    input  m_req, m_addr, m_wr_data, m_wr_en, m_count
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the EX data request and the IF fetch.
// The winner's command is latched into the m_* registers and held until the
// memory acks. Completion and read data are then routed back combinationally.
// Data wins by default. After STARVE_MAX consecutive data grants with a fetch
// waiting, the fetch is forced through.
// Ports:
//  clk    clock
//  clr_n  synchronous active-low reset
//  bus    mem_arbiter_if.master (requester, completion and memory signals)
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int COUNT_W    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  mem_arbiter_if.master  bus
);

  localparam logic [COUNT_W-1:0] CNT_NONE   = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] CNT_WORD   = COUNT_W'(3);
  localparam logic [3:0]         STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       d_pend, i_pend, grant_d, grant_i;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    d_pend    = (bus.d_req_count != CNT_NONE);
    i_pend    = bus.i_req;
    case (state)
      IDLE: begin
        // A waiting fetch overtakes data once the starvation limit is hit.
        if (d_pend && i_pend) begin
          grant_i = (starve_cnt >= STARVE_LIM);
          grant_d = ~grant_i;
        end else begin
          grant_d = d_pend;
          grant_i = i_pend;
        end
        if (grant_d)      state_nxt = GNT_D;
        else if (grant_i) state_nxt = GNT_I;
      end
      GNT_D, GNT_I: begin
        if (bus.m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.d_done    = (state == GNT_D) && bus.m_ack;
    bus.i_done    = (state == GNT_I) && bus.m_ack;
    bus.d_rd_data = bus.d_done ? bus.m_rd_data : WORD_W'(0);
    bus.i_rd_data = bus.i_done ? bus.m_rd_data : WORD_W'(0);
    bus.d_stall   = d_pend && !bus.d_done;
    bus.i_stall   = i_pend && !bus.i_done;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      bus.m_req     <= 1'b0;
      bus.m_addr    <= ADDR_W'(0);
      bus.m_wr_data <= WORD_W'(0);
      bus.m_wr_en   <= 1'b0;
      bus.m_count   <= CNT_NONE;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        bus.m_req     <= 1'b1;
        bus.m_addr    <= bus.d_req_addr;
        bus.m_wr_data <= bus.d_req_wr_data;
        bus.m_wr_en   <= bus.d_req_wr_en;
        bus.m_count   <= bus.d_req_count;
        // Only consecutive data grants that actually block a fetch count.
        starve_cnt    <= i_pend ? sat_inc(starve_cnt) : 4'd0;
      end else if (grant_i) begin
        bus.m_req     <= 1'b1;
        bus.m_addr    <= bus.i_req_addr;
        bus.m_wr_data <= WORD_W'(0);
        bus.m_wr_en   <= 1'b0;
        bus.m_count   <= CNT_WORD;
        starve_cnt    <= 4'd0;
      end else if (state != IDLE && bus.m_ack) begin
        bus.m_req     <= 1'b0;
        bus.m_count   <= CNT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int STARVE = 4;

  typedef struct {
    bit          who;    // 0 = data, 1 = fetch
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  cnt;
  } cmd_t;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .WORD_W(32), .COUNT_W(2)) bus ();

  mem_arbiter #(.ADDR_W(32), .WORD_W(32), .COUNT_W(2), .STARVE_MAX(STARVE)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  cmd_t        d_list[$];
  logic [31:0] i_list[$];
  cmd_t        exp_q[$];
  bit          grant_log[$];

  bit          m_busy = 1'b0;
  int          m_starve = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          perturb = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    if (d_list.size() > 0) begin
      bus.d_req_addr    = d_list[0].addr;
      bus.d_req_wr_data = d_list[0].wdata;
      bus.d_req_wr_en   = d_list[0].wr;
      bus.d_req_count   = d_list[0].cnt;
      if (perturb && m_busy && !exp_q[0].who)
        bus.d_req_addr = d_list[0].addr ^ 32'h0000_FFFF;
    end else begin
      bus.d_req_addr    = 32'h0;
      bus.d_req_wr_data = 32'h0;
      bus.d_req_wr_en   = 1'b0;
      bus.d_req_count   = 2'd0;
    end
    bus.i_req      = (i_list.size() > 0);
    bus.i_req_addr = (i_list.size() > 0) ? i_list[0] : 32'h0;
  endtask

  // One clock: check at negedge, update the reference model at posedge,
  // then drive the memory response and requester inputs just after it.
  task automatic step();
    logic dp, ip, ack, ed, ei, rst_now, gi;
    cmd_t c;
    @(negedge clk);
    dp      = (bus.d_req_count != 2'd0);
    ip      = bus.i_req;
    ack     = bus.m_ack;
    rst_now = !clr_n;
    ed      = m_busy && !exp_q[0].who && ack;
    ei      = m_busy &&  exp_q[0].who && ack;
    chk("d_done",    bus.d_done,    ed);
    chk("i_done",    bus.i_done,    ei);
    chk("d_stall",   bus.d_stall,   dp && !ed);
    chk("i_stall",   bus.i_stall,   ip && !ei);
    chk("m_req",     bus.m_req,     m_busy);
    chk("d_rd_data", bus.d_rd_data, ed ? mem_rdata : 32'h0);
    chk("i_rd_data", bus.i_rd_data, ei ? mem_rdata : 32'h0);
    if (m_busy) begin
      chk("m_addr",    bus.m_addr,    exp_q[0].addr);
      chk("m_wr_data", bus.m_wr_data, exp_q[0].wdata);
      chk("m_wr_en",   bus.m_wr_en,   exp_q[0].wr);
      chk("m_count",   bus.m_count,   exp_q[0].cnt);
    end else begin
      chk("m_count_idle", bus.m_count, 2'd0);
    end
    if (ed || ei) begin
      grant_log.push_back(exp_q[0].who);
      void'(exp_q.pop_front());
    end

    @(posedge clk);
    if (rst_now) begin
      m_busy   = 1'b0;
      m_starve = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (ack) m_busy = 1'b0;
    end else if (dp || ip) begin
      gi = (dp && ip) ? (m_starve >= STARVE) : ip;
      if (gi) begin
        c = '{who: 1'b1, addr: i_list[0], wdata: 32'h0, wr: 1'b0, cnt: 2'd3};
        m_starve = 0;
      end else begin
        c = d_list[0];
        c.who = 1'b0;
        m_starve = ip ? ((m_starve == 15) ? 15 : m_starve + 1) : 0;
      end
      exp_q.push_back(c);
      m_busy = 1'b1;
    end

    #1;
    if (ed) void'(d_list.pop_front());
    if (ei) void'(i_list.pop_front());
    if (rst_now || bus.m_ack) begin
      bus.m_ack = 1'b0;
      wait_cnt  = 0;
    end else if (bus.m_req) begin
      if (wait_cnt >= ack_delay) bus.m_ack = 1'b1;
      else wait_cnt++;
    end
    mem_rdata     = $urandom;
    bus.m_rd_data = mem_rdata;
    drive_reqs();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((d_list.size() > 0 || i_list.size() > 0 || m_busy) && n < max_cycles) begin
      step();
      n++;
    end
    chk("timeout", (n >= max_cycles), 1'b0);
    step();
  endtask

  function automatic cmd_t dcmd(input logic [31:0] a, input logic [31:0] w,
                                input logic wr, input logic [1:0] cnt);
    return '{who: 1'b0, addr: a, wdata: w, wr: wr, cnt: cnt};
  endfunction

  initial begin
    string pat;
    // Reset with both requests pending.
    clr_n      = 1'b0;
    bus.m_ack  = 1'b0;
    bus.m_rd_data = 32'h0;
    d_list.push_back(dcmd(32'h0000_1000, 32'h1111_2222, 1'b0, 2'd3));
    i_list.push_back(32'h0000_0040);
    drive_reqs();
    step();
    step();
    chk("rst_m_addr",    bus.m_addr,    32'h0);
    chk("rst_m_wr_data", bus.m_wr_data, 32'h0);
    chk("rst_m_wr_en",   bus.m_wr_en,   1'b0);
    chk("rst_d_stall",   bus.d_stall,   1'b1);
    chk("rst_i_stall",   bus.i_stall,   1'b1);
    clr_n = 1'b1;
    grant_log.delete();
    run_until_idle(50);
    chk("first_grant_data", grant_log[0], 1'b0);
    chk("second_grant_fetch", grant_log[1], 1'b1);

    // Lone fetch, ack three cycles after m_req.
    ack_delay = 3;
    i_list.push_back(32'h0000_0100);
    drive_reqs();
    run_until_idle(50);

    // Store arriving while a fetch is outstanding.
    i_list.push_back(32'h0000_0300);
    drive_reqs();
    step();
    step();
    d_list.push_back(dcmd(32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 2'd1));
    drive_reqs();
    grant_log.delete();
    run_until_idle(50);
    chk("store_after_fetch_0", grant_log[0], 1'b1);
    chk("store_after_fetch_1", grant_log[1], 1'b0);

    // Starvation: both pending continuously, immediate ack.
    ack_delay = 0;
    for (int k = 0; k < 12; k++)
      d_list.push_back(dcmd(32'h0000_3000 + 32'(k * 4), $urandom, k[0], 2'(1 + (k % 3))));
    for (int k = 0; k < 3; k++)
      i_list.push_back(32'h0000_0800 + 32'(k * 4));
    drive_reqs();
    grant_log.delete();
    run_until_idle(200);
    pat = "DDDDIDDDDIDDDDI";
    chk("order_len", grant_log.size(), 15);
    for (int k = 0; k < 15 && k < grant_log.size(); k++)
      chk($sformatf("order_%0d", k), grant_log[k], (pat[k] == "I"));

    // Address changes while the load is granted; latched command must hold.
    ack_delay = 3;
    perturb   = 1'b1;
    d_list.push_back(dcmd(32'h0000_4000, 32'h0BAD_F00D, 1'b0, 2'd3));
    drive_reqs();
    run_until_idle(50);
    perturb = 1'b0;

    // Reset during a fetch grant, then a stray ack in IDLE.
    ack_delay = 5;
    i_list.push_back(32'h0000_0500);
    drive_reqs();
    step();
    step();
    chk("t6_granted", bus.m_req, 1'b1);
    clr_n = 1'b0;
    i_list.delete();
    drive_reqs();
    step();
    clr_n     = 1'b1;
    bus.m_ack = 1'b1;
    step();
    chk("t6_m_req_after_stray", bus.m_req, 1'b0);
    step();
    chk("t6_m_req_idle", bus.m_req, 1'b0);
    ack_delay = 1;
    i_list.push_back(32'h0000_0600);
    drive_reqs();
    grant_log.delete();
    run_until_idle(50);
    chk("t6_recovery_grant", grant_log.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
